// File: rtl/rv32_data_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv32_data_mem_pkg
// Shared types for the data-memory port between the MEM stage and the
// data-memory responder.
//   mem_size_t  : access width (byte / half / word); encoding 3 is illegal
//   mem_req_t   : one latched load/store request
//   mem_rsp_t   : response payload (extended load data + error flag)
//   dmem_state_t: responder FSM states
// ---------------------------------------------------------------------------
package rv32_data_mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      mem_size_t   size;
      logic        is_unsigned;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
   } mem_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   // Wait counter width; covers LATENCY up to 15.
   localparam int WAIT_CNT_W = 4;

   // True when the size encoding is illegal or the address is not naturally
   // aligned for that size. Takes the raw 2-bit size so encoding 3 is caught.
   function automatic logic access_fault_align(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
      logic fault;
      case (size)
         2'd0:    fault = 1'b0;
         2'd1:    fault = addr_lo[0];
         2'd2:    fault = (addr_lo != 2'b00);
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/rv32_data_mem_if.sv
// ---------------------------------------------------------------------------
// rv32_data_mem_if
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave).
//   req_valid / req_ready : request handshake, accepted when both are high
//   req_we, req_addr, req_wdata, req_size, req_unsigned : request fields
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata, rsp_error  : response payload, meaningful only with rsp_valid
// ---------------------------------------------------------------------------
interface rv32_data_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/rv32_mem_lane_align.sv
// ---------------------------------------------------------------------------
// rv32_mem_lane_align
// Purely combinational byte-lane steering for the data memory.
//   Store path: st_size, st_lo, st_wdata -> st_byte_en, st_wdata_lanes
//               (right-aligned store data replicated onto every lane so the
//               byte enables alone pick the destination)
//   Load path : ld_size, ld_lo, ld_unsigned, ld_word -> ld_rdata
//               (selected lane(s) shifted to bit 0, then sign/zero extended)
// The two paths are independent so the store side can work on the request
// being committed while the load side works on the registered response.
// ---------------------------------------------------------------------------
module rv32_mem_lane_align
   import rv32_data_mem_pkg::*;
(
   input  mem_size_t   st_size,
   input  logic [1:0]  st_lo,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_byte_en,
   output logic [31:0] st_wdata_lanes,

   input  mem_size_t   ld_size,
   input  logic [1:0]  ld_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_rdata
);

   logic [31:0] ld_shifted;
   logic        ld_sign;

   always_comb begin
      st_byte_en     = 4'b0000;
      st_wdata_lanes = st_wdata;
      case (st_size)
         MEM_BYTE: begin
            st_byte_en     = 4'b0001 << st_lo;
            st_wdata_lanes = {4{st_wdata[7:0]}};
         end
         MEM_HALF: begin
            st_byte_en     = st_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata_lanes = {2{st_wdata[15:0]}};
         end
         MEM_WORD: begin
            st_byte_en     = 4'b1111;
         end
         default: begin
            // Illegal size never writes.
            st_byte_en     = 4'b0000;
         end
      endcase
   end

   always_comb begin
      ld_shifted = ld_word >> {ld_lo, 3'b000};
      ld_sign    = 1'b0;
      ld_rdata   = ld_word;
      case (ld_size)
         MEM_BYTE: begin
            ld_sign  = ~ld_unsigned & ld_shifted[7];
            ld_rdata = {{24{ld_sign}}, ld_shifted[7:0]};
         end
         MEM_HALF: begin
            ld_sign  = ~ld_unsigned & ld_shifted[15];
            ld_rdata = {{16{ld_sign}}, ld_shifted[15:0]};
         end
         default: begin
            // Word loads ignore the unsigned flag.
            ld_rdata = ld_word;
         end
      endcase
   end

endmodule

// File: rtl/rv32_data_mem.sv
// ---------------------------------------------------------------------------
// rv32_data_mem
// Data-memory responder on the far end of the MEM stage data port. Accepts
// one load/store at a time, waits LATENCY cycles, then pulses rsp_valid for
// one cycle with the extended load data or an error flag.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rv32_data_mem_if slave port (request handshake + response)
// Parameters:
//   DEPTH_WORDS : 32-bit words in the array (power of two)
//   BASE_ADDR   : byte address of word 0, aligned to DEPTH_WORDS*4
//   LATENCY     : wait states between acceptance and response (0..15)
// ---------------------------------------------------------------------------
module rv32_data_mem
   import rv32_data_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          LATENCY     = 0
) (
   input  logic           clk,
   input  logic           reset,
   rv32_data_mem_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic ZERO_LAT = (LATENCY == 0);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (LATENCY > 0) ? WAIT_CNT_W'(LATENCY - 1) : '0;

   dmem_state_t           state_reg, state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
   mem_req_t              req_reg;
   mem_req_t              live_req;
   mem_req_t              cur_req;
   logic                  accept;
   logic                  enter_resp;
   logic                  in_range;
   logic                  req_err;
   logic                  wr_en;
   logic                  rd_en;
   logic [IDX_W-1:0]      word_idx;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_lanes;
   logic [31:0]           rd_word;
   logic [31:0]           ld_rdata;

   // Registered response state; rsp_rdata is derived only from these.
   logic                  rsp_valid_reg;
   logic                  rsp_error_reg;
   logic                  rsp_clear_reg;
   mem_size_t             ld_size_reg;
   logic [1:0]            ld_lo_reg;
   logic                  ld_unsigned_reg;
   mem_rsp_t              rsp_out;

   assign bus.req_ready = (state_reg == ST_IDLE) && !reset;
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      live_req.we          = bus.req_we;
      live_req.addr        = bus.req_addr;
      live_req.wdata       = bus.req_wdata;
      live_req.size        = mem_size_t'(bus.req_size);
      live_req.is_unsigned = bus.req_unsigned;
   end

   // With zero wait states the array is accessed on the acceptance edge
   // itself, so in IDLE the live bus fields stand in for the latched copy.
   assign cur_req = (state_reg == ST_IDLE) ? live_req : req_reg;

   // BASE_ADDR is aligned to the array size, so range checking reduces to
   // comparing the bits above the array index, and the word index is simply
   // the address bits just above the byte offset.
   assign in_range = (cur_req.addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
   assign req_err  = !in_range ||
                     access_fault_align(cur_req.size, cur_req.addr[1:0]);
   assign word_idx = cur_req.addr[IDX_W+1:2];

   assign wr_en = enter_resp && !reset && cur_req.we  && !req_err;
   assign rd_en = enter_resp && !reset && !cur_req.we && !req_err;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      enter_resp    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (ZERO_LAT) begin
                  state_next = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next    = ST_WAIT;
                  wait_cnt_next = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_reg == '0) begin
               state_next = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg - 1'b1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request latch; only written on acceptance, which cannot happen in reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_reg <= live_req;
      end
   end

   // ---------------- Response registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_reg   <= 1'b0;
         rsp_error_reg   <= 1'b0;
         rsp_clear_reg   <= 1'b1;
         ld_size_reg     <= MEM_BYTE;
         ld_lo_reg       <= 2'b00;
         ld_unsigned_reg <= 1'b0;
      end else begin
         rsp_valid_reg <= enter_resp;
         if (enter_resp) begin
            rsp_error_reg   <= req_err;
            // Stores and faulting accesses report zero data.
            rsp_clear_reg   <= req_err || cur_req.we;
            ld_size_reg     <= cur_req.size;
            ld_lo_reg       <= cur_req.addr[1:0];
            ld_unsigned_reg <= cur_req.is_unsigned;
         end
      end
   end

   // ---------------- Lane steering ----------------
   rv32_mem_lane_align u_lane_align (
      .st_size        (cur_req.size),
      .st_lo          (cur_req.addr[1:0]),
      .st_wdata       (cur_req.wdata),
      .st_byte_en     (byte_en),
      .st_wdata_lanes (wdata_lanes),
      .ld_size        (ld_size_reg),
      .ld_lo          (ld_lo_reg),
      .ld_unsigned    (ld_unsigned_reg),
      .ld_word        (rd_word),
      .ld_rdata       (ld_rdata)
   );

   // ---------------- Storage ----------------
   // One byte-wide array per lane keeps byte-enable writes a plain
   // single-port RAM pattern with a registered read.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_en && byte_en[gi]) begin
            lane_mem[word_idx] <= wdata_lanes[8*gi +: 8];
         end
         if (rd_en) begin
            rd_q <= lane_mem[word_idx];
         end
      end

      assign rd_word[8*gi +: 8] = rd_q;
   end

   // Every term here is a register captured on the RESP-entry edge, so the
   // response data is stable for the whole cycle and holds until the next
   // response.
   assign rsp_out.rdata = rsp_clear_reg ? 32'h0 : ld_rdata;
   assign rsp_out.error = rsp_error_reg;

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_out.rdata;
   assign bus.rsp_error = rsp_out.error;

endmodule

// File: tb/tb_rv32_data_mem.sv
// ---------------------------------------------------------------------------
// tb_rv32_data_mem
// Drives two responders (LATENCY 0 and LATENCY 3) sharing one clock.
// Expected responses are queued per instance when a request is accepted and
// compared when rsp_valid is seen, including the cycle it arrives on.
// ---------------------------------------------------------------------------
module tb_rv32_data_mem;
   import rv32_data_mem_pkg::*;

   logic clk = 1'b0;
   logic reset0;
   logic reset3;

   always #5 clk = ~clk;

   rv32_data_mem_if if0 ();
   rv32_data_mem_if if3 ();

   rv32_data_mem #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0001_0000),
      .LATENCY     (0)
   ) u_dut0 (
      .clk   (clk),
      .reset (reset0),
      .bus   (if0)
   );

   rv32_data_mem #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0001_0000),
      .LATENCY     (3)
   ) u_dut3 (
      .clk   (clk),
      .reset (reset3),
      .bus   (if3)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       tag;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q3[$];
   exp_t m0;
   exp_t m3;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns);
      if (d == 0) begin
         if0.req_valid = v; if0.req_we = we; if0.req_addr = addr;
         if0.req_wdata = wdata; if0.req_size = size; if0.req_unsigned = uns;
      end else begin
         if3.req_valid = v; if3.req_we = we; if3.req_addr = addr;
         if3.req_wdata = wdata; if3.req_size = size; if3.req_unsigned = uns;
      end
   endtask

   function automatic logic ready_of(input int d);
      return (d == 0) ? if0.req_ready : if3.req_ready;
   endfunction

   // Presents a request on the next falling edge and holds it until accepted.
   // accept_cyc is the cycle count just before the acceptance edge; stalls is
   // the number of falling edges on which the request was held but not ready.
   task automatic req(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_rsp,
                      input string tag, output int accept_cyc,
                      output int stalls);
      exp_t e;
      bit   done;
      int   lat;
      lat        = (d == 0) ? 0 : 3;
      stalls     = 0;
      done       = 1'b0;
      accept_cyc = -1;
      @(negedge clk);
      drive(d, 1'b1, we, addr, wdata, size, uns);
      for (int i = 0; i < 100 && !done; i++) begin
         if (ready_of(d)) begin
            accept_cyc = cyc;
            @(posedge clk);
            done = 1'b1;
         end else begin
            stalls++;
            @(negedge clk);
         end
      end
      if (!done) begin
         check({tag, " accept timeout"}, 32'd0, 32'd1);
         drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      end else if (exp_rsp) begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         e.cyc   = accept_cyc + lat + 1;
         e.tag   = tag;
         if (d == 0) exp_q0.push_back(e);
         else        exp_q3.push_back(e);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
   endtask

   // Response monitors
   always @(negedge clk) begin
      if (if0.rsp_valid === 1'b1) begin
         if (exp_q0.size() == 0) begin
            check("dut0 unexpected rsp_valid", 32'd1, 32'd0);
         end else begin
            m0 = exp_q0.pop_front();
            $display("dut0 %-14s rdata=%h err=%b cyc=%0d", m0.tag,
                     if0.rsp_rdata, if0.rsp_error, cyc);
            check({m0.tag, " rdata"}, if0.rsp_rdata, m0.rdata);
            check({m0.tag, " error"}, 32'(if0.rsp_error), 32'(m0.err));
            check({m0.tag, " cycle"}, 32'(cyc), 32'(m0.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (if3.rsp_valid === 1'b1) begin
         if (exp_q3.size() == 0) begin
            check("dut3 unexpected rsp_valid", 32'd1, 32'd0);
         end else begin
            m3 = exp_q3.pop_front();
            $display("dut3 %-14s rdata=%h err=%b cyc=%0d", m3.tag,
                     if3.rsp_rdata, if3.rsp_error, cyc);
            check({m3.tag, " rdata"}, if3.rsp_rdata, m3.rdata);
            check({m3.tag, " error"}, 32'(if3.rsp_error), 32'(m3.err));
            check({m3.tag, " cycle"}, 32'(cyc), 32'(m3.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, s, a1, s1, a2, s2;
      reset0 = 1'b1;
      reset3 = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      repeat (3) @(negedge clk);

      // Reset state (request presented to prove it is not consumed in reset)
      drive(0, 1'b1, 1'b1, 32'h0001_0000, 32'h0, 2'd2, 1'b0);
      #1;
      check("rst0 ready",     32'(if0.req_ready), 32'd0);
      check("rst0 rsp_valid", 32'(if0.rsp_valid), 32'd0);
      check("rst0 rdata",     if0.rsp_rdata,      32'd0);
      check("rst0 error",     32'(if0.rsp_error), 32'd0);
      check("rst3 ready",     32'(if3.req_ready), 32'd0);
      check("rst3 rsp_valid", 32'(if3.rsp_valid), 32'd0);
      check("rst3 rdata",     if3.rsp_rdata,      32'd0);
      check("rst3 error",     32'(if3.rsp_error), 32'd0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      reset0 = 1'b0;
      reset3 = 1'b0;
      #1;
      check("post-rst0 ready", 32'(if0.req_ready), 32'd1);
      check("post-rst3 ready", 32'(if3.req_ready), 32'd1);

      // ---------------- LATENCY 0 ----------------
      req(0, 1, 32'h0001_0004, 32'hDEAD_BEEF, 2'd2, 0, 32'h0,         0, 1, "st_w 10004",  a, s);
      req(0, 0, 32'h0001_0004, 32'h0,         2'd2, 0, 32'hDEAD_BEEF, 0, 1, "ld_w 10004",  a, s);
      check("lat0 stalls between requests", 32'(s), 32'd1);
      req(0, 0, 32'h0001_0007, 32'h0,         2'd0, 0, 32'hFFFF_FFDE, 0, 1, "ld_b 10007 s", a, s);
      req(0, 0, 32'h0001_0007, 32'h0,         2'd0, 1, 32'h0000_00DE, 0, 1, "ld_b 10007 u", a, s);
      req(0, 0, 32'h0001_0004, 32'h0,         2'd1, 0, 32'hFFFF_BEEF, 0, 1, "ld_h 10004 s", a, s);
      req(0, 0, 32'h0001_0006, 32'h0,         2'd1, 1, 32'h0000_DEAD, 0, 1, "ld_h 10006 u", a, s);
      req(0, 1, 32'h0001_0000, 32'h1111_1111, 2'd2, 0, 32'h0,         0, 1, "st_w 10000",  a, s);
      req(0, 1, 32'h0001_0008, 32'h2222_2222, 2'd2, 0, 32'h0,         0, 1, "st_w 10008",  a, s);
      req(0, 1, 32'h0001_0005, 32'hAB00_0055, 2'd0, 0, 32'h0,         0, 1, "st_b 10005",  a, s);
      req(0, 0, 32'h0001_0004, 32'h0,         2'd2, 1, 32'hDEAD_55EF, 0, 1, "ld_w 10004 b", a, s);
      req(0, 0, 32'h0001_0000, 32'h0,         2'd2, 0, 32'h1111_1111, 0, 1, "ld_w 10000",  a, s);
      req(0, 0, 32'h0001_0008, 32'h0,         2'd2, 0, 32'h2222_2222, 0, 1, "ld_w 10008",  a, s);
      req(0, 0, 32'h0001_0005, 32'h0,         2'd0, 0, 32'h0000_0055, 0, 1, "ld_b 10005",  a, s);
      req(0, 1, 32'h0001_000A, 32'hA5A5_1234, 2'd1, 0, 32'h0,         0, 1, "st_h 1000A",  a, s);
      req(0, 0, 32'h0001_0008, 32'h0,         2'd2, 0, 32'h1234_2222, 0, 1, "ld_w 10008 h", a, s);
      // Error cases
      req(0, 0, 32'h0001_0002, 32'h0,         2'd2, 0, 32'h0,         1, 1, "err ld_w mis", a, s);
      req(0, 0, 32'h0001_0001, 32'h0,         2'd1, 0, 32'h0,         1, 1, "err ld_h mis", a, s);
      req(0, 0, 32'h0000_FFFC, 32'h0,         2'd2, 0, 32'h0,         1, 1, "err below",   a, s);
      req(0, 0, 32'h0001_1000, 32'h0,         2'd2, 0, 32'h0,         1, 1, "err above",   a, s);
      req(0, 0, 32'h0001_0004, 32'h0,         2'd3, 0, 32'h0,         1, 1, "err size3",   a, s);
      req(0, 1, 32'h0001_0002, 32'hFFFF_FFFF, 2'd2, 0, 32'h0,         1, 1, "err st_w mis", a, s);
      req(0, 0, 32'h0001_0000, 32'h0,         2'd2, 0, 32'h1111_1111, 0, 1, "ld_w 10000 e", a, s);
      req(0, 0, 32'h0001_0004, 32'h0,         2'd2, 0, 32'hDEAD_55EF, 0, 1, "ld_w 10004 e", a, s);
      // Last word of the array
      req(0, 1, 32'h0001_0FFC, 32'h0BAD_F00D, 2'd2, 0, 32'h0,         0, 1, "st_w 10FFC",  a, s);
      req(0, 0, 32'h0001_0FFC, 32'h0,         2'd2, 0, 32'h0BAD_F00D, 0, 1, "ld_w 10FFC",  a, s);
      idle(0);

      // ---------------- LATENCY 3 ----------------
      req(3, 1, 32'h0001_0008, 32'hA0B0_C0D0, 2'd2, 0, 32'h0,         0, 1, "st_w 10008",  a, s);
      req(3, 0, 32'h0001_0008, 32'h0,         2'd2, 0, 32'hA0B0_C0D0, 0, 1, "ld_w 10008 a", a1, s1);
      req(3, 0, 32'h0001_0008, 32'h0,         2'd0, 0, 32'hFFFF_FFD0, 0, 1, "ld_b 10008 b", a2, s2);
      check("lat3 stalls while busy", 32'(s2), 32'd4);
      check("lat3 acceptance spacing", 32'(a2 - a1), 32'd5);

      // Reset in the second wait cycle drops the store
      req(3, 1, 32'h0001_0008, 32'h1234_5678, 2'd2, 0, 32'h0, 0, 0, "st_w aborted", a, s);
      @(negedge clk);
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      reset3 = 1'b1;
      #1;
      check("mid-wait reset ready", 32'(if3.req_ready), 32'd0);
      @(negedge clk);
      reset3 = 1'b0;
      #1;
      check("idle after reset", 32'(if3.req_ready), 32'd1);
      repeat (6) @(negedge clk);
      req(3, 0, 32'h0001_0008, 32'h0, 2'd2, 0, 32'hA0B0_C0D0, 0, 1, "ld_w after rst", a, s);
      idle(3);

      repeat (10) @(negedge clk);
      check("dut0 pending responses", 32'(exp_q0.size()), 32'd0);
      check("dut3 pending responses", 32'(exp_q3.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
